// File: rtl/cdb_pkg.sv
// Shared types and constants for the common data bus arbiter and its per-source buffers.
package cdb_pkg;

  localparam int unsigned CDB_NUM_SRC = 4;
  localparam int unsigned CDB_TAG_W   = 6;
  localparam int unsigned CDB_DATA_W  = 32;
  localparam int unsigned CDB_SRC_W   = $clog2(CDB_NUM_SRC);

  typedef enum logic [CDB_SRC_W-1:0] {
    SRC_INT  = 2'd0,
    SRC_MULT = 2'd1,
    SRC_DIV  = 2'd2,
    SRC_MEM  = 2'd3
  } cdb_src_e;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic                  wr;
    logic                  branch;
    logic                  branch_taken;
    logic                  jalr;
  } cdb_entry_t;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic                  branch;
    logic                  branch_taken;
    logic                  jalr;
    logic                  busy;
    cdb_src_e              src;
  } cdb_out_t;

  function automatic cdb_entry_t make_entry(
    input logic [CDB_TAG_W-1:0]  tag,
    input logic [CDB_DATA_W-1:0] data,
    input logic                  wr,
    input logic                  branch,
    input logic                  branch_taken,
    input logic                  jalr
  );
    cdb_entry_t e;
    e.tag          = tag;
    e.data         = data;
    e.wr           = wr;
    e.branch       = branch;
    e.branch_taken = branch_taken;
    e.jalr         = jalr;
    return e;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Source-side result handshakes and the registered CDB broadcast, grouped as one bundle.
interface cdb_arbiter_if
  import cdb_pkg::*;
#(
  parameter int unsigned TAG_W  = CDB_TAG_W,
  parameter int unsigned DATA_W = CDB_DATA_W
) ();

  logic              int_push;
  logic              int_ready;
  logic [TAG_W-1:0]  int_tag;
  logic [DATA_W-1:0] int_data;
  logic              int_wr;
  logic              int_branch;
  logic              int_branch_taken;
  logic              int_jalr;

  logic              mult_push;
  logic              mult_ready;
  logic [TAG_W-1:0]  mult_tag;
  logic [DATA_W-1:0] mult_data;
  logic              mult_wr;

  logic              div_push;
  logic              div_ready;
  logic [TAG_W-1:0]  div_tag;
  logic [DATA_W-1:0] div_data;
  logic              div_wr;

  logic              mem_push;
  logic              mem_ready;
  logic [TAG_W-1:0]  mem_tag;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wr;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_branch;
  logic              cdb_branch_taken;
  logic              cdb_jalr;
  logic              cdb_busy;
  logic [1:0]        cdb_src;

  // Execution queues plus CDB consumers.
  modport master (
    output int_push, int_tag, int_data, int_wr, int_branch, int_branch_taken, int_jalr,
    output mult_push, mult_tag, mult_data, mult_wr,
    output div_push, div_tag, div_data, div_wr,
    output mem_push, mem_tag, mem_data, mem_wr,
    input  int_ready, mult_ready, div_ready, mem_ready,
    input  cdb_valid, cdb_tag, cdb_data, cdb_branch, cdb_branch_taken, cdb_jalr,
    input  cdb_busy, cdb_src
  );

  // The arbiter.
  modport slave (
    input  int_push, int_tag, int_data, int_wr, int_branch, int_branch_taken, int_jalr,
    input  mult_push, mult_tag, mult_data, mult_wr,
    input  div_push, div_tag, div_data, div_wr,
    input  mem_push, mem_tag, mem_data, mem_wr,
    output int_ready, mult_ready, div_ready, mem_ready,
    output cdb_valid, cdb_tag, cdb_data, cdb_branch, cdb_branch_taken, cdb_jalr,
    output cdb_busy, cdb_src
  );

endinterface

// File: rtl/cdb_src_fifo.sv
// Per-source result buffer; ready and empty are registered flags so the handshake never
// depends on the same-cycle pop.
module cdb_src_fifo
  import cdb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  cdb_entry_t entry_i,
  input  logic       pop_i,
  output logic       ready_o,
  output logic       empty_o,
  output cdb_entry_t head_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  cdb_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q, ready_d;
  logic             empty_q, empty_d;
  logic             do_push;
  logic             do_pop;

  // Pointer/count update; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    do_push  = push_i && ready_q;
    do_pop   = pop_i && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
    if (do_pop)  rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
    case ({do_push, do_pop})
      2'b10:   count_d = CNT_W'(count_q + 1'b1);
      2'b01:   count_d = CNT_W'(count_q - 1'b1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d < CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      empty_q  <= empty_d;
    end
  end

  // Payload storage needs no reset: it is only observed while the buffer is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

  assign ready_o = ready_q;
  assign empty_o = empty_q;
  assign head_c  = mem_q[rd_ptr_q];

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: four buffered result sources share one registered broadcast slot per cycle.
// Define CDB_ARB_RR_EN for round-robin (int->mult->div->mem); otherwise fixed div>mult>mem>int.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned TAG_W  = CDB_TAG_W,
  parameter int unsigned DATA_W = CDB_DATA_W
) (
  input logic          clk,
  input logic          rst,
  cdb_arbiter_if.slave bus
);

  logic [CDB_NUM_SRC-1:0] src_push;
  logic [CDB_NUM_SRC-1:0] src_ready;
  logic [CDB_NUM_SRC-1:0] src_empty;
  logic [CDB_NUM_SRC-1:0] src_pop;
  cdb_entry_t             src_entry [CDB_NUM_SRC];
  cdb_entry_t             src_head  [CDB_NUM_SRC];

  logic                   grant_vld_c;
  logic [CDB_SRC_W-1:0]   grant_idx_c;
  cdb_entry_t             win_c;
  cdb_out_t               cdb_q, cdb_d;

`ifdef CDB_ARB_RR_EN
  logic [CDB_SRC_W-1:0]   last_grant_q, last_grant_d;
  logic [CDB_SRC_W-1:0]   rr_cand_c;
`endif

  // Only the integer queue resolves branches; other sources carry zero branch bits.
  assign src_push = {bus.mem_push, bus.div_push, bus.mult_push, bus.int_push};

  assign src_entry[SRC_INT]  = make_entry(CDB_TAG_W'(bus.int_tag), CDB_DATA_W'(bus.int_data),
                                          bus.int_wr, bus.int_branch, bus.int_branch_taken,
                                          bus.int_jalr);
  assign src_entry[SRC_MULT] = make_entry(CDB_TAG_W'(bus.mult_tag), CDB_DATA_W'(bus.mult_data),
                                          bus.mult_wr, 1'b0, 1'b0, 1'b0);
  assign src_entry[SRC_DIV]  = make_entry(CDB_TAG_W'(bus.div_tag), CDB_DATA_W'(bus.div_data),
                                          bus.div_wr, 1'b0, 1'b0, 1'b0);
  assign src_entry[SRC_MEM]  = make_entry(CDB_TAG_W'(bus.mem_tag), CDB_DATA_W'(bus.mem_data),
                                          bus.mem_wr, 1'b0, 1'b0, 1'b0);

  for (genvar g = 0; g < int'(CDB_NUM_SRC); g++) begin : g_src
    cdb_src_fifo #(
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (src_push[g]),
      .entry_i(src_entry[g]),
      .pop_i  (src_pop[g]),
      .ready_o(src_ready[g]),
      .empty_o(src_empty[g]),
      .head_c (src_head[g])
    );
  end

  assign bus.int_ready  = src_ready[SRC_INT];
  assign bus.mult_ready = src_ready[SRC_MULT];
  assign bus.div_ready  = src_ready[SRC_DIV];
  assign bus.mem_ready  = src_ready[SRC_MEM];

  // Winner selection over the non-empty buffers.
  always_comb begin
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
`ifdef CDB_ARB_RR_EN
    rr_cand_c   = '0;
    for (int unsigned i = 1; i <= CDB_NUM_SRC; i++) begin
      rr_cand_c = CDB_SRC_W'(last_grant_q + CDB_SRC_W'(i));
      if (!grant_vld_c && !src_empty[rr_cand_c]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = rr_cand_c;
      end
    end
`else
    if (!src_empty[SRC_DIV]) begin
      grant_vld_c = 1'b1;
      grant_idx_c = SRC_DIV;
    end else if (!src_empty[SRC_MULT]) begin
      grant_vld_c = 1'b1;
      grant_idx_c = SRC_MULT;
    end else if (!src_empty[SRC_MEM]) begin
      grant_vld_c = 1'b1;
      grant_idx_c = SRC_MEM;
    end else if (!src_empty[SRC_INT]) begin
      grant_vld_c = 1'b1;
      grant_idx_c = SRC_INT;
    end
`endif
  end

  // Pop the winner and stage its head for the broadcast register.
  always_comb begin
    src_pop = '0;
    cdb_d   = '0;
    win_c   = src_head[grant_idx_c];
    if (grant_vld_c) begin
      src_pop[grant_idx_c] = 1'b1;
      cdb_d.valid          = win_c.wr;
      cdb_d.tag            = win_c.tag;
      cdb_d.data           = win_c.data;
      cdb_d.branch         = win_c.branch;
      cdb_d.branch_taken   = win_c.branch_taken;
      cdb_d.jalr           = win_c.jalr;
      cdb_d.busy           = 1'b1;
      cdb_d.src            = cdb_src_e'(grant_idx_c);
    end
  end

`ifdef CDB_ARB_RR_EN
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_vld_c) last_grant_d = grant_idx_c;
  end

  // Reset value points at mem so the integer source is searched first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_grant_q <= SRC_MEM;
    else      last_grant_q <= last_grant_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cdb_q <= '0;
    else      cdb_q <= cdb_d;
  end

  assign bus.cdb_valid        = cdb_q.valid;
  assign bus.cdb_tag          = TAG_W'(cdb_q.tag);
  assign bus.cdb_data         = DATA_W'(cdb_q.data);
  assign bus.cdb_branch       = cdb_q.branch;
  assign bus.cdb_branch_taken = cdb_q.branch_taken;
  assign bus.cdb_jalr         = cdb_q.jalr;
  assign bus.cdb_busy         = cdb_q.busy;
  assign bus.cdb_src          = cdb_q.src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.TAG_W(CDB_TAG_W), .DATA_W(CDB_DATA_W)) bus ();

  cdb_arbiter #(
    .DEPTH (DEPTH),
    .TAG_W (CDB_TAG_W),
    .DATA_W(CDB_DATA_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [3:0]            push_v;
  logic [CDB_TAG_W-1:0]  tag_v  [4];
  logic [CDB_DATA_W-1:0] data_v [4];
  logic [3:0]            wr_v;
  logic                  br_v, bt_v, jalr_v;
  logic [3:0]            rdy_v;

  assign bus.int_push         = push_v[0];
  assign bus.int_tag          = tag_v[0];
  assign bus.int_data         = data_v[0];
  assign bus.int_wr           = wr_v[0];
  assign bus.int_branch       = br_v;
  assign bus.int_branch_taken = bt_v;
  assign bus.int_jalr         = jalr_v;
  assign bus.mult_push        = push_v[1];
  assign bus.mult_tag         = tag_v[1];
  assign bus.mult_data        = data_v[1];
  assign bus.mult_wr          = wr_v[1];
  assign bus.div_push         = push_v[2];
  assign bus.div_tag          = tag_v[2];
  assign bus.div_data         = data_v[2];
  assign bus.div_wr           = wr_v[2];
  assign bus.mem_push         = push_v[3];
  assign bus.mem_tag          = tag_v[3];
  assign bus.mem_data         = data_v[3];
  assign bus.mem_wr           = wr_v[3];
  assign rdy_v = {bus.mem_ready, bus.div_ready, bus.mult_ready, bus.int_ready};

  // Reference model: one queue per source plus the previous winner.
  cdb_entry_t            mq [4][$];
  int                    lg;
  logic                  e_valid, e_branch, e_taken, e_jalr, e_busy;
  logic [CDB_TAG_W-1:0]  e_tag;
  logic [CDB_DATA_W-1:0] e_data;
  logic [1:0]            e_src;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) mq[s].delete();
    lg       = 3;
    e_valid  = 1'b0;
    e_tag    = '0;
    e_data   = '0;
    e_branch = 1'b0;
    e_taken  = 1'b0;
    e_jalr   = 1'b0;
    e_busy   = 1'b0;
    e_src    = '0;
  endtask

  function automatic int pick();
    int order [4];
`ifdef CDB_ARB_RR_EN
    for (int i = 0; i < 4; i++) order[i] = (lg + 1 + i) % 4;
`else
    order = '{2, 1, 3, 0};
`endif
    for (int i = 0; i < 4; i++) if (mq[order[i]].size() != 0) return order[i];
    return -1;
  endfunction

  task automatic model_step();
    bit         acc [4];
    int         w;
    cdb_entry_t e;
    for (int s = 0; s < 4; s++) acc[s] = (push_v[s] === 1'b1) && (mq[s].size() < int'(DEPTH));
    w = pick();
    e_valid = 1'b0; e_tag = '0; e_data = '0; e_branch = 1'b0;
    e_taken = 1'b0; e_jalr = 1'b0; e_busy = 1'b0; e_src = '0;
    if (w >= 0) begin
      e        = mq[w].pop_front();
      e_valid  = e.wr;
      e_tag    = e.tag;
      e_data   = e.data;
      e_branch = e.branch;
      e_taken  = e.branch_taken;
      e_jalr   = e.jalr;
      e_busy   = 1'b1;
      e_src    = 2'(w);
      lg       = w;
    end
    for (int s = 0; s < 4; s++) begin
      if (acc[s]) begin
        e.tag          = tag_v[s];
        e.data         = data_v[s];
        e.wr           = wr_v[s];
        e.branch       = (s == 0) ? br_v   : 1'b0;
        e.branch_taken = (s == 0) ? bt_v   : 1'b0;
        e.jalr         = (s == 0) ? jalr_v : 1'b0;
        mq[s].push_back(e);
      end
    end
  endtask

  task automatic check_outputs();
    chk("cdb_valid",  64'(bus.cdb_valid),        64'(e_valid));
    chk("cdb_tag",    64'(bus.cdb_tag),          64'(e_tag));
    chk("cdb_data",   64'(bus.cdb_data),         64'(e_data));
    chk("cdb_branch", 64'(bus.cdb_branch),       64'(e_branch));
    chk("cdb_taken",  64'(bus.cdb_branch_taken), 64'(e_taken));
    chk("cdb_jalr",   64'(bus.cdb_jalr),         64'(e_jalr));
    chk("cdb_busy",   64'(bus.cdb_busy),         64'(e_busy));
    chk("cdb_src",    64'(bus.cdb_src),          64'(e_src));
    for (int s = 0; s < 4; s++)
      chk($sformatf("ready%0d", s), 64'(rdy_v[s]), 64'(mq[s].size() < int'(DEPTH)));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_step();
    else     model_reset();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    push_v = '0;
    rst    = 1'b0;
    #1;
    model_reset();
    step();
    step();
    rst = 1'b1;
  endtask

  logic [1:0]           exp_src [4];
  logic [CDB_TAG_W-1:0] exp_tag [4];
  logic [CDB_TAG_W-1:0] got [$];
  logic [CDB_TAG_W-1:0] mtag [3];
  int                   mi;
  bit                   macc;

  initial begin
    rst    = 1'b0;
    push_v = '0;
    wr_v   = '0;
    br_v   = 1'b0;
    bt_v   = 1'b0;
    jalr_v = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tag_v[s]  = '0;
      data_v[s] = '0;
    end
    model_reset();

    // Reset state, then readiness on release.
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b1;
    #1;
    for (int s = 0; s < 4; s++) chk("ready_after_reset", 64'(rdy_v[s]), 64'd1);

    // Single integer result: visible one cycle after acceptance, then idle.
    push_v    = 4'b0001;
    tag_v[0]  = 6'd0;
    data_v[0] = 32'h0000_000A;
    wr_v[0]   = 1'b1;
    step();
    push_v = '0;
    step();
    chk("single_valid", 64'(bus.cdb_valid), 64'd1);
    chk("single_tag",   64'(bus.cdb_tag),   64'd0);
    chk("single_data",  64'(bus.cdb_data),  64'h0A);
    chk("single_src",   64'(bus.cdb_src),   64'd0);
    step();
    chk("single_idle", 64'(bus.cdb_busy), 64'd0);

    // All four sources at once from a fresh reset.
    do_reset();
`ifdef CDB_ARB_RR_EN
    exp_src = '{2'd0, 2'd1, 2'd2, 2'd3};
    exp_tag = '{6'd1, 6'd4, 6'd5, 6'd6};
`else
    exp_src = '{2'd2, 2'd1, 2'd3, 2'd0};
    exp_tag = '{6'd5, 6'd4, 6'd6, 6'd1};
`endif
    push_v = 4'hF;
    wr_v   = 4'hF;
    tag_v  = '{6'd1, 6'd4, 6'd5, 6'd6};
    for (int s = 0; s < 4; s++) data_v[s] = $urandom;
    step();
    push_v = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("order_src", 64'(bus.cdb_src), 64'(exp_src[k]));
      chk("order_tag", 64'(bus.cdb_tag), 64'(exp_tag[k]));
    end

    // Branch resolution without a register write.
    push_v   = 4'b0001;
    tag_v[0] = 6'd9;
    wr_v[0]  = 1'b0;
    br_v     = 1'b1;
    bt_v     = 1'b1;
    jalr_v   = 1'b0;
    step();
    push_v = '0;
    br_v   = 1'b0;
    bt_v   = 1'b0;
    step();
    chk("br_busy",  64'(bus.cdb_busy),         64'd1);
    chk("br_valid", 64'(bus.cdb_valid),        64'd0);
    chk("br_bit",   64'(bus.cdb_branch),       64'd1);
    chk("br_taken", 64'(bus.cdb_branch_taken), 64'd1);
    chk("br_jalr",  64'(bus.cdb_jalr),         64'd0);

    // Three mult results against continuous div traffic; held push retries until accepted.
    mtag = '{6'd10, 6'd11, 6'd12};
    mi   = 0;
    got.delete();
    wr_v = 4'hF;
    for (int cyc = 0; cyc < 60 && !(mi == 3 && got.size() == 3); cyc++) begin
      push_v[2] = (cyc < 12);
      tag_v[2]  = 6'(32 + cyc);
      data_v[2] = $urandom;
      push_v[1] = (mi < 3);
      tag_v[1]  = mtag[(mi < 3) ? mi : 2];
      data_v[1] = $urandom;
      macc = push_v[1] && (mq[1].size() < int'(DEPTH));
      step();
      if (macc) begin
        mi++;
`ifndef CDB_ARB_RR_EN
        if (mi == 2) chk("mult_full", 64'(bus.mult_ready), 64'd0);
`endif
      end
      if (bus.cdb_busy === 1'b1 && bus.cdb_src === 2'd1) got.push_back(bus.cdb_tag);
    end
    push_v = '0;
    chk("mult_count", 64'(got.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      if (k < got.size()) chk("mult_order", 64'(got[k]), 64'(mtag[k]));

    // Reset while entries are buffered: nothing of them reaches the bus afterwards.
    push_v = 4'hF;
    for (int s = 0; s < 4; s++) begin
      tag_v[s]  = 6'($urandom);
      data_v[s] = $urandom;
    end
    step();
    push_v = '0;
    step();
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_async_busy", 64'(bus.cdb_busy), 64'd0);
    check_outputs();
    step();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_rst_busy", 64'(bus.cdb_busy), 64'd0);
    end

    // Random traffic: a saturating phase then a sparse phase.
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < 4; s++) begin
        push_v[s] = (c < 200) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 3) == 0);
        tag_v[s]  = 6'($urandom);
        data_v[s] = $urandom;
        wr_v[s]   = 1'($urandom_range(0, 1));
      end
      br_v   = 1'($urandom_range(0, 1));
      bt_v   = 1'($urandom_range(0, 1));
      jalr_v = 1'($urandom_range(0, 1));
      step();
    end
    push_v = '0;
    repeat (8) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
